// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared register, adjustment-op and PC-index definitions
// for the decode stage and its field decoder.
package decode_queue_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef logic [4:0] regind_t;
  typedef logic [XLEN_DEFAULT-1:0] regval_t;
  typedef enum logic [2:0] {
    ADJ_ADD = 3'd0,
    ADJ_LSL = 3'd1,
    ADJ_LSR = 3'd2,
    ADJ_ASR = 3'd3,
    ADJ_ROR = 3'd4
  } adj_op_e;
  localparam regind_t PC_INDEX = 5'd31;
  // Instruction shift field [5:4] maps onto the codes following Add
  function automatic adj_op_e shift_op(input logic [1:0] s);
    return adj_op_e'({1'b0, s} + 3'd1);
  endfunction
endpackage

// File: rtl/decode_queue_fields.sv
// decode_fields: combinational split of a 32-bit instruction into read-stage
// controls, including the CNVZ predicate evaluated against live flags.
module decode_fields
  import decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [3:0]      i_flags,
  output logic            o_live,
  output logic [3:0]      o_op,
  output regind_t         o_dst,
  output logic            o_dst_mem,
  output logic            o_right_mem,
  output regind_t         o_left,
  output regind_t         o_right,
  output logic [XLEN-1:0] o_adj,
  output adj_op_e         o_adj_op
);
  logic w_reg, w_ind, w_mem;
  assign w_reg = i_instr[17];
  assign w_ind = i_instr[11];
  assign w_mem = i_instr[10];
  assign o_live = i_instr[31] == |(i_instr[30:27] & i_flags);
  assign o_op = i_instr[26:23];
  assign o_dst = i_instr[22:18];
  assign o_dst_mem = w_reg & w_ind & w_mem;
  assign o_right_mem = w_reg & w_ind & !w_mem;
  assign o_left = !w_reg ? '0 : !w_ind ? i_instr[16:12] : w_mem ? '0 : i_instr[22:18];
  assign o_right = !w_reg ? '0 : !w_ind ? i_instr[10:6] : i_instr[16:12];
  assign o_adj = !w_reg ? {{(XLEN-17){i_instr[16]}}, i_instr[16:0]}
               : !w_ind ? {{(XLEN-4){1'b0}}, i_instr[3:0]}
               : {{(XLEN-10){i_instr[9]}}, i_instr[9:0]};
  assign o_adj_op = (w_reg & !w_ind) ? shift_op(i_instr[5:4]) : ADJ_ADD;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: fetch-side instruction queue feeding a registered decode stage,
// with empty-queue bypass, PC-write squash and external flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instruction,
  input  logic [3:0]      flags,
  input  logic            flush,
  input  logic            out_hold,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_operation,
  output logic [4:0]      out_destination,
  output logic            out_destination_is_memory,
  output logic            out_right_is_memory,
  output logic [4:0]      out_left_register,
  output logic [4:0]      out_right_register,
  output logic [XLEN-1:0] out_adjustment,
  output logic [2:0]      out_adjustment_operation,
  output logic            out_has_flushed,
  output logic            pc_changing
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN+31:0] r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0] r_count;
  logic w_empty, w_issue, w_bypass, w_pop, w_push;
  logic [XLEN-1:0] w_pc;
  logic [31:0] w_instr;
  logic w_live, w_dst_mem, w_right_mem;
  logic [3:0] w_op;
  regind_t w_dst, w_left, w_right;
  logic [XLEN-1:0] w_adj;
  adj_op_e w_adj_op;
  // DEPTH is a power of two, so the count reaches DEPTH exactly when its top bit sets
  assign in_ready = !r_count[AW];
  assign w_empty = r_count == '0;
  assign w_issue = !flush & !out_hold & (!w_empty | in_valid);
  assign w_bypass = w_issue & w_empty;
  assign w_pop = w_issue & !w_empty;
  assign {w_pc, w_instr} = w_empty ? {in_pc, in_instruction} : r_mem[r_head];
  assign pc_changing = w_issue & w_live & !w_dst_mem & (w_dst == PC_INDEX);
  assign w_push = in_valid & in_ready & !w_bypass & !flush & !pc_changing;
  decode_fields #(.XLEN(XLEN)) u_fields (
    .i_instr(w_instr), .i_flags(flags), .o_live(w_live), .o_op(w_op), .o_dst(w_dst),
    .o_dst_mem(w_dst_mem), .o_right_mem(w_right_mem), .o_left(w_left),
    .o_right(w_right), .o_adj(w_adj), .o_adj_op(w_adj_op)
  );
  always_ff @(posedge clock)
    if (w_push) r_mem[r_tail] <= {in_pc, in_instruction};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else if (flush | pc_changing) begin
      r_head <= r_tail;
      r_count <= '0;
    end else begin
      r_head <= r_head + AW'(w_pop);
      r_tail <= r_tail + AW'(w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_operation <= '0;
      out_destination <= '0;
      out_destination_is_memory <= 1'b0;
      out_right_is_memory <= 1'b0;
      out_left_register <= '0;
      out_right_register <= '0;
      out_adjustment <= '0;
      out_adjustment_operation <= '0;
      out_has_flushed <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_has_flushed <= 1'b0;
    end else if (w_issue) begin
      out_valid <= w_live;
      out_pc <= w_pc;
      out_operation <= w_op;
      out_destination <= w_dst;
      out_destination_is_memory <= w_dst_mem;
      out_right_is_memory <= w_right_mem;
      out_left_register <= w_left;
      out_right_register <= w_right;
      out_adjustment <= w_adj;
      out_adjustment_operation <= w_adj_op;
      out_has_flushed <= pc_changing;
    end
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with an integrated fetch-side instruction queue, sitting between fetch and register read. It buffers up to DEPTH fetched {pc, instruction} pairs and evaluates each instruction's CNVZ predicate against live flags. It decodes the fixed 32-bit format into read-stage controls and squashes younger work on a PC write or an external flush. Unlike the single-register decode it replaces, it has XLEN-wide values, a valid/ready fetch handshake, a bypass path and flush support.

## Interface
- XLEN, 32: width of PC, immediates and adjustments; must be ≥ 32.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- clock  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid / in_ready  input / output  1 / 1  fetch handshake; transfer when both high.
- in_pc  input  XLEN  PC of in_instruction.
- in_instruction  input  32  instruction word.
- flags  input  4  current {C,N,V,Z}.
- flush  input  1  squash everything; from a later stage.
- out_hold  input  1  read stage stall.
- out_valid  output  1  output register holds a live instruction.
- out_pc  output  XLEN.
- out_operation  output  4  instr[26:23].
- out_destination  output  5  instr[22:18].
- out_destination_is_memory, out_right_is_memory  output  1 each.
- out_left_register, out_right_register  output  5 each.
- out_adjustment  output  XLEN.
- out_adjustment_operation  output  3.
- out_has_flushed  output  1  previous issued instruction wrote PC.
- pc_changing  output  1  combinational; the instruction issuing this cycle writes PC.

## Operation
- Field decode is identical to the existing format: [31] is the non-zero-active predicate, [30:27] the CNVZ mask, [17] is_register, [16:0] the signed immediate, [16:12] sr1, [11] is_indirect, [10:6] sr2, [5:4] the shift operation, [3:0] the shift amount, [10] is_to_memory, [9:0] the signed indirect adjustment.
- Sign extension goes to XLEN. The shift amount is zero-extended.
- Predicate: live = instr[31] == |(instr[30:27] & flags). Flags are sampled in the issue cycle.
- Immediate form: left = right = 0; adjustment = the immediate; operation = Add.
- Register-direct form: left = sr1; right = sr2; adjustment = shift amount; operation = shift op.
- Indirect form: left = is_to_memory ? 0 : dr; right = sr1; adjustment = the indirect adjustment; operation = Add.
- destination_is_memory = is_register & is_indirect & is_to_memory. right_is_memory = is_register & is_indirect & !is_to_memory.
- Issue occurs when the queue is non-empty (or the bypass is active) and out_hold is low. It loads the output register and pops one entry.
- A predicated-off instruction is consumed and loads out_valid = 0.
- pc_changing = issue & live & !destination_is_memory & dr == PC_INDEX.
- When pc_changing is high:
  - All remaining queue entries are discarded.
  - Any same-cycle push is dropped.
  - out_has_flushed = 1 is loaded with this instruction, then cleared on the next issue.
- flush has priority over everything except reset:
  - The queue empties.
  - out_valid ← 0 and out_has_flushed ← 0.
  - A same-cycle push is dropped.
  - out_hold is ignored for clearing.
- While out_hold is high, all out_* registers are frozen. Pushes continue while in_ready is high.

## Timing
- Reset values: out_valid = 0, out_has_flushed = 0, all other out_* = 0, count = 0, in_ready = 1, pc_changing = 0.
- Reset mid-operation discards all queued entries immediately (asynchronous).
- in_ready = (count < DEPTH). It is registered-state based and never depends on out_hold in the same cycle.
- At full, a simultaneous pop does not admit a push.
- Bypass: with the queue empty, out_hold low and in_valid high, the input is decoded and issued directly; its output is visible after one edge (latency 1).
- Otherwise the entry is enqueued, and latency = 1 + the number of older entries ahead of it.
- Simultaneous push and pop with a non-empty queue: count is unchanged.
- Pointers wrap modulo DEPTH.
- Flags are read combinationally at issue. A flag update in the same cycle as issue is not seen.

## Structure
- The shared package holds:
  - the regind_t (5-bit) and regval_t types, with regval_t generalised to an XLEN-parametrised use;
  - the adjustment-operation enum (Add and the shift codes);
  - PC_INDEX.
- Sub-module decode_fields: a combinational instruction plus flags to decoded-fields function with an XLEN parameter. It is instantiated once, on the queue-head/bypass mux output.
- The queue is an inline circular buffer: log2(DEPTH)+1-bit count, and head/tail pointers.

## Test plan
- Reset then bypass:
  - Stimulus: push ADD immediate 0x1FFFF, dr = 3, mask 0, bit31 = 0, XLEN = 32.
  - Required: next cycle out_valid = 1, adjustment = 0xFFFFFFFF, left = right = 0, op = Add.
- Predicate:
  - Stimulus: flags Z = 1; push a mask=Z instruction with bit31 = 1, then one with bit31 = 0.
  - Required: the first gives out_valid = 1, the second out_valid = 0.
- Back-pressure:
  - Stimulus: out_hold = 1; push 5 instructions with DEPTH = 4.
  - Required: in_ready drops after 4; release hold; instructions issue in order, one per cycle, with outputs frozen during hold.
- PC write:
  - Stimulus: queue [mov PC, X, Y]; issue.
  - Required: pc_changing = 1 for one cycle; X and Y are never issued; out_has_flushed = 1 with the PC write and clears on the next issue.
- Indirect store:
  - Stimulus: instr[17] = 1, [11] = 1, [10] = 1, dr = 31, adjustment 0x3FF.
  - Required: destination_is_memory = 1, left = 0, adjustment = −1, pc_changing = 0.
- Flush:
  - Stimulus: assert flush with a full queue, out_hold = 1 and in_valid = 1.
  - Required: next cycle count = 0, out_valid = 0, in_ready = 1, push dropped.
